// File: rtl/sync_reg_bank.sv
// sync_reg_bank: NREGS x WIDTH register bank with one write port, two
// registered read ports (A/B) and a per-register pending scoreboard.
// Optional macro SYNC_REG_BANK_BYPASS_EN selects write-first forwarding on a
// same-index read/write collision; when undefined, reads return old contents.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   we/wr_sel/wr_data    write port (clears pending on the written index)
//   rsv/rsv_sel          reserve request (sets pending on rsv_sel)
//   rd_en_x/rd_sel_x     read requests for ports A and B
//   rd_data_x/rd_ok_x    registered read data and operand-valid flag
//   pending              scoreboard vector, bit i = register i pending
module sync_reg_bank #(
  parameter int unsigned  WIDTH = 16,
  parameter int unsigned  NREGS = 8,
  localparam int unsigned SELW  = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [SELW-1:0]  wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rsv,
  input  logic [SELW-1:0]  rsv_sel,
  input  logic             rd_en_a,
  input  logic [SELW-1:0]  rd_sel_a,
  input  logic             rd_en_b,
  input  logic [SELW-1:0]  rd_sel_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic             rd_ok_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_ok_b,
  output logic [NREGS-1:0] pending
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d;
  logic [WIDTH-1:0] rd_data_b_q, rd_data_b_d;
  logic             rd_ok_a_q, rd_ok_a_d;
  logic             rd_ok_b_q, rd_ok_b_d;

  logic wr_hit, rsv_hit, a_hit, b_hit;

  // Index range check; widened so the compare stays meaningful for
  // non-power-of-two NREGS.
  function automatic logic in_range(input logic [SELW-1:0] s);
    return (32'(s) < NREGS);
  endfunction

  assign wr_hit  = we  && in_range(wr_sel);
  assign rsv_hit = rsv && in_range(rsv_sel);
  assign a_hit   = in_range(rd_sel_a);
  assign b_hit   = in_range(rd_sel_b);

  // Next-state: write, then reserve (reserve wins on same index), then reads
  // from pre-edge state.
  always_comb begin
    regs_d      = regs_q;
    pending_d   = pending_q;
    rd_data_a_d = rd_data_a_q;
    rd_ok_a_d   = rd_ok_a_q;
    rd_data_b_d = rd_data_b_q;
    rd_ok_b_d   = rd_ok_b_q;

    if (wr_hit) begin
      regs_d[wr_sel]    = wr_data;
      pending_d[wr_sel] = 1'b0;
    end
    if (rsv_hit) begin
      pending_d[rsv_sel] = 1'b1;
    end

    if (rd_en_a) begin
      if (a_hit) begin
        rd_data_a_d = regs_q[rd_sel_a];
        rd_ok_a_d   = ~pending_q[rd_sel_a];
`ifdef SYNC_REG_BANK_BYPASS_EN
        // Forward the in-flight write; a same-cycle reserve marks it stale.
        if (wr_hit && (wr_sel == rd_sel_a)) begin
          rd_data_a_d = wr_data;
          rd_ok_a_d   = ~(rsv_hit && (rsv_sel == rd_sel_a));
        end
`endif
      end else begin
        rd_data_a_d = '0;
        rd_ok_a_d   = 1'b1;
      end
    end

    if (rd_en_b) begin
      if (b_hit) begin
        rd_data_b_d = regs_q[rd_sel_b];
        rd_ok_b_d   = ~pending_q[rd_sel_b];
`ifdef SYNC_REG_BANK_BYPASS_EN
        if (wr_hit && (wr_sel == rd_sel_b)) begin
          rd_data_b_d = wr_data;
          rd_ok_b_d   = ~(rsv_hit && (rsv_sel == rd_sel_b));
        end
`endif
      end else begin
        rd_data_b_d = '0;
        rd_ok_b_d   = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
      pending_q   <= '0;
      rd_data_a_q <= '0;
      rd_ok_a_q   <= 1'b0;
      rd_data_b_q <= '0;
      rd_ok_b_q   <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      pending_q   <= pending_d;
      rd_data_a_q <= rd_data_a_d;
      rd_ok_a_q   <= rd_ok_a_d;
      rd_data_b_q <= rd_data_b_d;
      rd_ok_b_q   <= rd_ok_b_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_ok_a   = rd_ok_a_q;
  assign rd_data_b = rd_data_b_q;
  assign rd_ok_b   = rd_ok_b_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_sync_reg_bank.sv
// Testbench for sync_reg_bank: two instances (NREGS=8 and NREGS=6) share
// stimulus; a behavioural model per instance predicts every output each cycle.
module tb_sync_reg_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [2:0]  wr_sel;
  logic [15:0] wr_data;
  logic        rsv;
  logic [2:0]  rsv_sel;
  logic        rd_en_a;
  logic [2:0]  rd_sel_a;
  logic        rd_en_b;
  logic [2:0]  rd_sel_b;

  logic [15:0] da8, db8, da6, db6;
  logic        oka8, okb8, oka6, okb6;
  logic [7:0]  pend8;
  logic [5:0]  pend6;

  int checks = 0;
  int errors = 0;

  // Model state: index 0 -> 8-register bank, index 1 -> 6-register bank.
  logic [15:0] m_regs [2][8];
  bit          m_pend [2][8];
  logic [15:0] m_da [2];
  logic [15:0] m_db [2];
  bit          m_oka [2];
  bit          m_okb [2];

  always #5 clk = ~clk;

  sync_reg_bank #(.WIDTH(16), .NREGS(8)) u_dut8 (
    .clk(clk), .reset(reset), .we(we), .wr_sel(wr_sel), .wr_data(wr_data),
    .rsv(rsv), .rsv_sel(rsv_sel), .rd_en_a(rd_en_a), .rd_sel_a(rd_sel_a),
    .rd_en_b(rd_en_b), .rd_sel_b(rd_sel_b), .rd_data_a(da8), .rd_ok_a(oka8),
    .rd_data_b(db8), .rd_ok_b(okb8), .pending(pend8)
  );

  sync_reg_bank #(.WIDTH(16), .NREGS(6)) u_dut6 (
    .clk(clk), .reset(reset), .we(we), .wr_sel(wr_sel), .wr_data(wr_data),
    .rsv(rsv), .rsv_sel(rsv_sel), .rd_en_a(rd_en_a), .rd_sel_a(rd_sel_a),
    .rd_en_b(rd_en_b), .rd_sel_b(rd_sel_b), .rd_data_a(da6), .rd_ok_a(oka6),
    .rd_data_b(db6), .rd_ok_b(okb6), .pending(pend6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value a read of 'sel' returns at this edge, as {ok, data}.
  function automatic logic [16:0] model_read(input int d, input int n, input logic [2:0] sel);
`ifdef SYNC_REG_BANK_BYPASS_EN
    if (we && int'(wr_sel) < n && wr_sel == sel)
      return {!(rsv && int'(rsv_sel) < n && rsv_sel == sel), wr_data};
`endif
    if (int'(sel) >= n) return {1'b1, 16'h0000};
    return {!m_pend[d][sel], m_regs[d][sel]};
  endfunction

  task automatic model_edge();
    logic [16:0] r;
    int n;
    for (int d = 0; d < 2; d++) begin
      n = (d == 0) ? 8 : 6;
      if (reset) begin
        for (int i = 0; i < 8; i++) begin
          m_regs[d][i] = 16'h0;
          m_pend[d][i] = 1'b0;
        end
        m_da[d] = 16'h0; m_db[d] = 16'h0; m_oka[d] = 1'b0; m_okb[d] = 1'b0;
      end else begin
        if (rd_en_a) begin
          r = model_read(d, n, rd_sel_a);
          m_oka[d] = r[16]; m_da[d] = r[15:0];
        end
        if (rd_en_b) begin
          r = model_read(d, n, rd_sel_b);
          m_okb[d] = r[16]; m_db[d] = r[15:0];
        end
        if (we && int'(wr_sel) < n) begin
          m_regs[d][wr_sel] = wr_data;
          m_pend[d][wr_sel] = 1'b0;
        end
        if (rsv && int'(rsv_sel) < n) m_pend[d][rsv_sel] = 1'b1;
      end
    end
  endtask

  function automatic logic [7:0] model_pend(input int d, input int n);
    logic [7:0] v = 8'h00;
    for (int i = 0; i < n; i++) v[i] = m_pend[d][i];
    return v;
  endfunction

  task automatic check_all(input string ph);
    chk({ph, " n8 rd_data_a"}, 32'(da8),  32'(m_da[0]));
    chk({ph, " n8 rd_ok_a"},   32'(oka8), 32'(m_oka[0]));
    chk({ph, " n8 rd_data_b"}, 32'(db8),  32'(m_db[0]));
    chk({ph, " n8 rd_ok_b"},   32'(okb8), 32'(m_okb[0]));
    chk({ph, " n8 pending"},   32'(pend8), 32'(model_pend(0, 8)));
    chk({ph, " n6 rd_data_a"}, 32'(da6),  32'(m_da[1]));
    chk({ph, " n6 rd_ok_a"},   32'(oka6), 32'(m_oka[1]));
    chk({ph, " n6 rd_data_b"}, 32'(db6),  32'(m_db[1]));
    chk({ph, " n6 rd_ok_b"},   32'(okb6), 32'(m_okb[1]));
    chk({ph, " n6 pending"},   32'(pend6), 32'(model_pend(1, 6)));
  endtask

  task automatic idle();
    we = 1'b0; wr_sel = 3'd0; wr_data = 16'h0; rsv = 1'b0; rsv_sel = 3'd0;
    rd_en_a = 1'b0; rd_sel_a = 3'd0; rd_en_b = 1'b0; rd_sel_b = 3'd0;
  endtask

  task automatic cycle(input string ph);
    @(posedge clk);
    model_edge();
    #1;
    check_all(ph);
  endtask

  initial begin
    logic [15:0] exp_col;
    idle();
    reset = 1'b1;

    // Reset for two cycles.
    cycle("rst0");
    cycle("rst1");
    reset = 1'b0;
    chk("reset rd_data_a", 32'(da8), 32'h0);
    chk("reset rd_ok_a", 32'(oka8), 32'h0);
    chk("reset rd_ok_b", 32'(okb8), 32'h0);
    chk("reset pending", 32'(pend8), 32'h0);

    // Write 0x1234 to reg 3, then read it on A.
    we = 1'b1; wr_sel = 3'd3; wr_data = 16'h1234;
    cycle("wr3");
    idle(); rd_en_a = 1'b1; rd_sel_a = 3'd3;
    cycle("rd3");
    chk("readback data", 32'(da8), 32'h1234);
    chk("readback ok", 32'(oka8), 32'h1);
    idle();

    // Full sweep: write i*0x1111, read A=i and B=7-i.
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; wr_sel = 3'(i); wr_data = 16'(i * 16'h1111);
      cycle("sweep_wr");
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      rd_en_a = 1'b1; rd_sel_a = 3'(i); rd_en_b = 1'b1; rd_sel_b = 3'(7 - i);
      cycle("sweep_rd");
      chk("sweep a", 32'(da8), 32'(i * 16'h1111));
      chk("sweep b", 32'(db8), 32'((7 - i) * 16'h1111));
    end
    idle();

    // Scoreboard on reg 5.
    rsv = 1'b1; rsv_sel = 3'd5;
    cycle("rsv5");
    chk("pending5 set", 32'(pend8[5]), 32'h1);
    idle(); rd_en_a = 1'b1; rd_sel_a = 3'd5;
    cycle("rd5_pend");
    chk("rd5 ok while pending", 32'(oka8), 32'h0);
    idle(); we = 1'b1; wr_sel = 3'd5; wr_data = 16'hBEEF;
    cycle("wr5");
    chk("pending5 clear", 32'(pend8[5]), 32'h0);
    idle(); rd_en_a = 1'b1; rd_sel_a = 3'd5;
    cycle("rd5_done");
    chk("rd5 data", 32'(da8), 32'hBEEF);
    chk("rd5 ok", 32'(oka8), 32'h1);
    idle();

    // Read/write collision on reg 2.
    we = 1'b1; wr_sel = 3'd2; wr_data = 16'h00AA;
    cycle("wr2");
    we = 1'b1; wr_sel = 3'd2; wr_data = 16'h0055; rd_en_a = 1'b1; rd_sel_a = 3'd2;
    cycle("col");
`ifdef SYNC_REG_BANK_BYPASS_EN
    exp_col = 16'h0055;
`else
    exp_col = 16'h00AA;
`endif
    chk("collision data", 32'(da8), 32'(exp_col));
    chk("collision ok", 32'(oka8), 32'h1);
    // Reserve + write + read on the same index.
    rsv = 1'b1; rsv_sel = 3'd2; wr_data = 16'h0077;
    cycle("col_rsv");
`ifdef SYNC_REG_BANK_BYPASS_EN
    chk("col_rsv ok", 32'(oka8), 32'h0);
    chk("col_rsv data", 32'(da8), 32'h0077);
`else
    chk("col_rsv ok", 32'(oka8), 32'h1);
    chk("col_rsv data", 32'(da8), 32'h0055);
`endif
    chk("col_rsv pending2", 32'(pend8[2]), 32'h1);
    idle();

    // Out-of-range on the 6-register bank.
    we = 1'b1; wr_sel = 3'd7; wr_data = 16'hFFFF; rsv = 1'b1; rsv_sel = 3'd6;
    cycle("oor_wr");
    idle();
    for (int i = 0; i < 6; i += 2) begin
      rd_en_a = 1'b1; rd_sel_a = 3'(i); rd_en_b = 1'b1; rd_sel_b = 3'(i + 1);
      cycle("oor_scan");
    end
    rd_en_a = 1'b1; rd_sel_a = 3'd6; rd_en_b = 1'b1; rd_sel_b = 3'd7;
    cycle("oor_rd");
    chk("oor rd_data_a", 32'(da6), 32'h0);
    chk("oor rd_ok_a", 32'(oka6), 32'h1);
    chk("oor rd_data_b", 32'(db6), 32'h0);
    chk("oor pending", 32'(pend6), 32'h04);
    idle();

    // Reset mid-operation discards reservations.
    rsv = 1'b1; rsv_sel = 3'd1;
    cycle("rsv1");
    rsv_sel = 3'd4;
    cycle("rsv4");
    idle(); reset = 1'b1;
    cycle("mid_rst");
    reset = 1'b0;
    chk("mid_rst pending8", 32'(pend8), 32'h0);
    chk("mid_rst pending6", 32'(pend6), 32'h0);
    rd_en_a = 1'b1; rd_sel_a = 3'd1; rd_en_b = 1'b1; rd_sel_b = 3'd4;
    cycle("post_rst");
    chk("post_rst ok_a", 32'(oka8), 32'h1);
    chk("post_rst ok_b", 32'(okb8), 32'h1);
    chk("post_rst data_a", 32'(da8), 32'h0);
    idle();

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 63) == 0);
      we       = 1'($urandom_range(0, 1));
      wr_sel   = 3'($urandom_range(0, 7));
      wr_data  = 16'($urandom);
      rsv      = ($urandom_range(0, 3) == 0);
      rsv_sel  = 3'($urandom_range(0, 7));
      rd_en_a  = 1'($urandom_range(0, 1));
      rd_sel_a = 3'($urandom_range(0, 7));
      rd_en_b  = 1'($urandom_range(0, 1));
      rd_sel_b = 3'($urandom_range(0, 7));
      cycle("rand");
    end
    idle(); reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
